adc_spi_responder: RTL

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_pkg.sv | 26 ++
 rtl/sync_edge.sv | 40 ++++
 rtl/adc_spi_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC SPI responder.
// Contents: FSM state type, frame geometry constants, decoded command payload.
package adc_pkg;

  localparam int unsigned ADC_BITS  = 10;
  localparam int unsigned CMD_BITS  = 4;
  localparam int unsigned TAIL_BITS = 9;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL_BIT,
    DATA,
    TAIL,
    HOLD
  } state_t;

  // Decoded command: SGL/DIFF followed by channel D2..D0
  typedef struct packed {
    logic       sgl_diff;
    logic [2:0] ch;
  } cmd_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer with combinational rise/fall pulses of the synchronized level.
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   d              : asynchronous input
//   q              : synchronized level (last flop of the chain)
//   rise_c, fall_c : one-cycle pulses when q changes 0->1 / 1->0
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 10-bit serial ADC (start bit, SGL/DIFF, D2..D0, null bit, B9..B0).
// Optional feature macro: ADC_LSB_TAIL_EN -- after B0, repeat B1..B9 LSB-first before holding low.
// Ports:
//   clk, rst_n          : system clock (>= 8x ad_clk), async active-low reset
//   ad_clk, cs_n, din   : SPI master inputs (asynchronous to clk)
//   dout, dout_oe       : response bit and its drive enable (0 = tri-state)
//   ch_sel, sgl_diff    : decoded channel / mode, held between frames
//   sample_req          : one-cycle request; sample_data is captured in that same cycle
//   sample_data         : conversion value for ch_sel
//   frame_done          : one-cycle pulse in the cycle B0 is driven
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ad_clk,
  input  logic       cs_n,
  input  logic       din,
  output logic       dout,
  output logic       dout_oe,
  output logic [2:0] ch_sel,
  output logic       sgl_diff,
  output logic       sample_req,
  input  logic [9:0] sample_data,
  output logic       frame_done
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic din_q, din_rise, din_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(ad_clk),
    .q(sclk_q), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n),
    .q(cs_q), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .d(din),
    .q(din_q), .rise_c(din_rise), .fall_c(din_fall)
  );

  // din is sampled as a level on ad_clk rises; remaining edge outputs are not needed
  assign unused_edges = din_rise ^ din_fall ^ cs_fall ^ sclk_q;

  // Frames are accepted only after cs_n has been genuinely seen high since reset.
  // prime fills once the synchronizer holds real samples instead of reset values.
  logic [SYNC_STAGES:0] prime;
  logic                 armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= '0;
      armed <= 1'b0;
    end else begin
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      if (prime[SYNC_STAGES] && cs_q) begin
        armed <= 1'b1;
      end
    end
  end

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CMD_BITS-2:0] cmd_q, cmd_nxt;
  logic [ADC_BITS-1:0] samp_q, samp_nxt;
  logic [2:0]          ch_nxt;
  logic                sgl_nxt, dout_nxt, oe_nxt, req_nxt, done_nxt;
  cmd_t                dec;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_q      <= '0;
      samp_q     <= '0;
      ch_sel     <= '0;
      sgl_diff   <= 1'b0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      sample_req <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cmd_q      <= cmd_nxt;
      samp_q     <= samp_nxt;
      ch_sel     <= ch_nxt;
      sgl_diff   <= sgl_nxt;
      dout       <= dout_nxt;
      dout_oe    <= oe_nxt;
      sample_req <= req_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state and output decode; cs_n rise overrides any coincident ad_clk edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_q;
    samp_nxt  = samp_q;
    ch_nxt    = ch_sel;
    sgl_nxt   = sgl_diff;
    dout_nxt  = dout;
    oe_nxt    = dout_oe;
    req_nxt   = 1'b0;
    done_nxt  = 1'b0;
    dec       = cmd_t'({cmd_q, din_q});

    // Conversion value is valid while sample_req is high
    if (sample_req) begin
      samp_nxt = sample_data;
    end

    if (cs_rise) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      dout_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt  = '0;
          cmd_nxt  = '0;
          dout_nxt = 1'b0;
          oe_nxt   = 1'b0;
          if (armed && !cs_q) begin
            state_nxt = WAIT_START;
          end
        end
        WAIT_START: begin
          if (sclk_rise && din_q) begin
            state_nxt = CMD;
            cnt_nxt   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_nxt = {cmd_q[CMD_BITS-3:0], din_q};
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMD_BITS - 1)) begin
              ch_nxt    = dec.ch;
              sgl_nxt   = dec.sgl_diff;
              req_nxt   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = NULL_BIT;
            end
          end
        end
        NULL_BIT: begin
          if (sclk_fall) begin
            dout_nxt  = 1'b0;
            oe_nxt    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            dout_nxt = samp_q[CNT_W'(ADC_BITS - 1) - cnt];
            cnt_nxt  = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ADC_BITS - 1)) begin
              done_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = TAIL;
            end
          end
        end
        TAIL: begin
`ifdef ADC_LSB_TAIL_EN
          if (sclk_fall) begin
            dout_nxt = samp_q[cnt + CNT_W'(1)];
            cnt_nxt  = cnt + CNT_W'(1);
            if (cnt == CNT_W'(TAIL_BITS - 1)) begin
              cnt_nxt   = '0;
              state_nxt = HOLD;
            end
          end
`else
          // B0 stays on the line until the next falling edge, handled in HOLD
          state_nxt = HOLD;
`endif
        end
        HOLD: begin
          oe_nxt = 1'b1;
          if (sclk_fall) begin
            dout_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
